// File: rtl/sram_arb_pkg.sv
// Shared types and geometry for the SRAM arbiter: 512K x 16 part, 32-bit word accesses
// split into two halfword cycles.
package sram_arb_pkg;

  localparam int unsigned SrAw  = 19;
  localparam int unsigned CpuAw = SrAw - 1;

  typedef enum logic [2:0] {
    StIdle,
    StVlo,
    StVhi,
    StClo,
    StChi
  } state_t;

endpackage

// File: rtl/sram_pins.sv
// Registered SRAM pin driver: decodes the state being entered into glitch-free strobes,
// address and write data.
module sram_pins
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  state_t           state_nxt,
  input  logic [CpuAw-1:0] adr,
  input  logic             wr,
  input  logic [3:0]       ben,
  input  logic [31:0]      wdata,
  output logic [SrAw-1:0]  sr_adr,
  output logic [15:0]      sr_dout,
  output logic             sr_doe,
  output logic             sr_ce_n,
  output logic             sr_oe_n,
  output logic             sr_we_n,
  output logic             sr_lb_n,
  output logic             sr_ub_n
);

  logic [SrAw-1:0] adr_d;
  logic [15:0]     dout_d;
  logic            doe_d, ce_d, oe_d, we_d, lb_d, ub_d, hi;

  always_comb begin
    hi     = (state_nxt == StVhi) || (state_nxt == StChi);
    adr_d  = sr_adr;
    dout_d = sr_dout;
    doe_d  = 1'b0;
    ce_d   = 1'b1;
    oe_d   = 1'b1;
    we_d   = 1'b1;
    lb_d   = 1'b1;
    ub_d   = 1'b1;
    unique case (state_nxt)
      StVlo, StVhi: begin
        ce_d  = 1'b0;
        oe_d  = 1'b0;
        lb_d  = 1'b0;
        ub_d  = 1'b0;
        adr_d = {adr, hi};
      end
      StClo, StChi: begin
        ce_d  = 1'b0;
        adr_d = {adr, hi};
        if (wr) begin
          doe_d  = 1'b1;
          we_d   = 1'b0;
          lb_d   = hi ? ~ben[2] : ~ben[0];
          ub_d   = hi ? ~ben[3] : ~ben[1];
          dout_d = hi ? wdata[31:16] : wdata[15:0];
        end else begin
          oe_d = 1'b0;
          lb_d = 1'b0;
          ub_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Async reset so the strobes release immediately when an access is aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_adr  <= '0;
      sr_dout <= '0;
      sr_doe  <= 1'b0;
      sr_ce_n <= 1'b1;
      sr_oe_n <= 1'b1;
      sr_we_n <= 1'b1;
      sr_lb_n <= 1'b1;
      sr_ub_n <= 1'b1;
    end else begin
      sr_adr  <= adr_d;
      sr_dout <= dout_d;
      sr_doe  <= doe_d;
      sr_ce_n <= ce_d;
      sr_oe_n <= oe_d;
      sr_we_n <= we_d;
      sr_lb_n <= lb_d;
      sr_ub_n <= ub_d;
    end
  end

endmodule

// File: rtl/sram_arb.sv
// Two-port SRAM arbiter: video fetches take priority over CPU reads/writes; each 32-bit
// word is moved as a low then a high halfword.
module sram_arb
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CpuAw-1:0] cpu_adr,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [3:0]       cpu_ben,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             vreq,
  input  logic [CpuAw-1:0] vadr,
  output logic [31:0]      viddata,
  output logic             vack,
  output logic [SrAw-1:0]  sr_adr,
  output logic [15:0]      sr_dout,
  input  logic [15:0]      sr_din,
  output logic             sr_doe,
  output logic             sr_ce_n,
  output logic             sr_oe_n,
  output logic             sr_we_n,
  output logic             sr_lb_n,
  output logic             sr_ub_n
);

  state_t           state_q, state_d;
  logic             pend_q, pend_d, pend_eff, cpu_req;
  logic [CpuAw-1:0] vadr_q, eff_vadr, acc_adr_q, acc_adr_d;
  logic [15:0]      lo_q;
  logic [31:0]      viddata_q, rdata_q;
  logic             vack_q, done_q;

  always_comb begin
    pend_eff = pend_q | vreq;
    eff_vadr = vreq ? vadr : vadr_q;
    cpu_req  = (cpu_rd | cpu_wr) & ~done_q;
    state_d  = state_q;
    unique case (state_q)
      StVlo:   state_d = StVhi;
      StClo:   state_d = StChi;
      // Grant points: IDLE, VHI, CHI. A CPU request is never re-granted straight out of CHI.
      default: begin
        if (pend_eff)                           state_d = StVlo;
        else if (cpu_req && state_q != StChi)   state_d = StClo;
        else                                    state_d = StIdle;
      end
    endcase
    pend_d    = (state_d == StVlo) ? 1'b0 : pend_eff;
    acc_adr_d = acc_adr_q;
    if (state_d == StVlo)      acc_adr_d = eff_vadr;
    else if (state_d == StClo) acc_adr_d = cpu_adr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      vadr_q    <= '0;
      acc_adr_q <= '0;
      lo_q      <= '0;
      viddata_q <= '0;
      rdata_q   <= '0;
      vack_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      acc_adr_q <= acc_adr_d;
      if (vreq) vadr_q <= vadr;
      if (state_q == StVlo || state_q == StClo) lo_q <= sr_din;
      if (state_q == StVhi) viddata_q <= {sr_din, lo_q};
      if (state_q == StChi && cpu_rd) rdata_q <= {sr_din, lo_q};
      vack_q <= (state_q == StVhi);
      done_q <= (state_q == StChi);
    end
  end

  assign cpu_stall = (cpu_rd | cpu_wr) & ~done_q;
  assign cpu_rdata = rdata_q;
  assign viddata   = viddata_q;
  assign vack      = vack_q;

  sram_pins u_pins (
    .clk      (clk),
    .rst      (rst),
    .state_nxt(state_d),
    .adr      (acc_adr_d),
    .wr       (cpu_wr),
    .ben      (cpu_ben),
    .wdata    (cpu_wdata),
    .sr_adr   (sr_adr),
    .sr_dout  (sr_dout),
    .sr_doe   (sr_doe),
    .sr_ce_n  (sr_ce_n),
    .sr_oe_n  (sr_oe_n),
    .sr_we_n  (sr_we_n),
    .sr_lb_n  (sr_lb_n),
    .sr_ub_n  (sr_ub_n)
  );

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: halfword SRAM model, word-level reference memory and a slot-based
// schedule model for grant timing.
module tb_sram_arb;

  localparam logic [5:0] PIdle = 6'b111110;  // {ce,oe,we,lb,ub,doe}
  localparam logic [5:0] PRd   = 6'b001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] cpu_adr = '0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [3:0]  cpu_ben = '0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic        cpu_stall;
  logic        vreq = 1'b0;
  logic [17:0] vadr = '0;
  logic [31:0] viddata;
  logic        vack;
  logic [18:0] sr_adr;
  logic [15:0] sr_dout, sr_din;
  logic        sr_doe, sr_ce_n, sr_oe_n, sr_we_n, sr_lb_n, sr_ub_n;

  logic        poke_en = 1'b0;
  logic [17:0] poke_adr = '0;
  logic [31:0] poke_dat = '0;
  logic [15:0] mem [0:524287];
  logic [31:0] ref_word [logic [17:0]];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sram_arb dut (
    .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_ben(cpu_ben), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vreq(vreq), .vadr(vadr), .viddata(viddata), .vack(vack), .sr_adr(sr_adr),
    .sr_dout(sr_dout), .sr_din(sr_din), .sr_doe(sr_doe), .sr_ce_n(sr_ce_n),
    .sr_oe_n(sr_oe_n), .sr_we_n(sr_we_n), .sr_lb_n(sr_lb_n), .sr_ub_n(sr_ub_n)
  );

  // Asynchronous SRAM: reads follow the address, writes commit at the edge ending the cycle.
  assign sr_din = (!sr_ce_n && !sr_oe_n) ? mem[sr_adr] : 16'h0;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[{poke_adr, 1'b0}] <= poke_dat[15:0];
      mem[{poke_adr, 1'b1}] <= poke_dat[31:16];
    end else if (!sr_ce_n && !sr_we_n) begin
      if (!sr_lb_n) mem[sr_adr][7:0]  <= sr_dout[7:0];
      if (!sr_ub_n) mem[sr_adr][15:8] <= sr_dout[15:8];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pv(logic [18:0] a, logic [5:0] s);
    return {7'd0, a, s};
  endfunction

  function automatic logic [31:0] act();
    return pv(sr_adr, {sr_ce_n, sr_oe_n, sr_we_n, sr_lb_n, sr_ub_n, sr_doe});
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic poke(logic [17:0] a, logic [31:0] d);
    poke_en  = 1'b1;
    poke_adr = a;
    poke_dat = d;
    ref_word[a] = d;
    nxt();
    poke_en = 1'b0;
  endtask

  task automatic run_vfetch(string tag);
    vreq = 1'b1;
    vadr = 18'h37FC0;
    mid();
    chk({tag, "_c0"}, 32'({sr_ce_n, sr_oe_n, sr_we_n, sr_doe}), 32'(4'b1110));
    nxt();
    vreq = 1'b0;
    vadr = 18'($urandom);
    mid();
    chk({tag, "_lo"}, act(), pv(19'h6FF80, PRd));
    nxt();
    mid();
    chk({tag, "_hi"}, act(), pv(19'h6FF81, PRd));
    chk({tag, "_vack_early"}, 32'(vack), 32'd0);
    nxt();
    mid();
    chk({tag, "_vack"}, 32'(vack), 32'd1);
    chk({tag, "_data"}, viddata, ref_word[18'h37FC0]);
    chk({tag, "_idle"}, act(), pv(19'h6FF81, PIdle));
    nxt();
    mid();
    chk({tag, "_vack_off"}, 32'(vack), 32'd0);
    chk({tag, "_hold"}, viddata, ref_word[18'h37FC0]);
    nxt();
  endtask

  initial begin
    int          op, voff, vs, cs, t, done_at, vack_at, nv;
    logic        is_wr, has_c, has_v, cdone;
    logic [17:0] ca, va;
    logic [31:0] rdat, vdat;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_pins", act(), pv(19'h0, PIdle));
    chk("rst_viddata", viddata, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_vack", 32'(vack), 32'd0);
    chk("rst_dout", 32'(sr_dout), 32'h0);
    cpu_rd = 1'b1;
    #1 chk("rst_stall", 32'(cpu_stall), 32'd1);
    cpu_rd = 1'b0;
    poke(18'h37FC0, 32'hDEADBEEF);
    poke(18'h00010, 32'h0);
    for (int k = 0; k < 16; k++) begin
      poke(18'(18'h00100 + k), $urandom);
      poke(18'(18'h20000 + k), $urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    nxt();

    run_vfetch("v043");

    // Byte-lane write, then read it back.
    cpu_adr = 18'h10; cpu_wdata = 32'h11223344; cpu_ben = 4'b0101; cpu_wr = 1'b1;
    mid(); chk("w_stall", 32'(cpu_stall), 32'd1);
    nxt(); mid();
    chk("w_lo", act(), pv(19'h20, 6'b010011));
    chk("w_lo_dout", 32'(sr_dout), 32'h3344);
    nxt(); mid();
    chk("w_hi", act(), pv(19'h21, 6'b010011));
    chk("w_hi_dout", 32'(sr_dout), 32'h1122);
    nxt(); mid();
    chk("w_done", 32'(cpu_stall), 32'd0);
    ref_word[18'h10] = merge(ref_word[18'h10], cpu_wdata, cpu_ben);
    nxt();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    mid(); chk("r_stall", 32'(cpu_stall), 32'd1);
    nxt(); mid(); chk("r_lo", act(), pv(19'h20, PRd));
    nxt(); mid(); chk("r_hi", act(), pv(19'h21, PRd));
    nxt(); mid();
    chk("r_done", 32'(cpu_stall), 32'd0);
    chk("r_data", cpu_rdata, ref_word[18'h10]);
    nxt();
    cpu_rd = 1'b0;
    mid();
    chk("r_hold", cpu_rdata, ref_word[18'h10]);
    chk("r_idle", act(), pv(19'h21, PIdle));
    nxt();

    // Zero byte enables: both cycles run, no lane strobes.
    cpu_wdata = 32'hFFFFFFFF; cpu_ben = 4'b0000; cpu_wr = 1'b1;
    nxt(); mid(); chk("w0_lo", act(), pv(19'h20, 6'b010111));
    nxt(); mid(); chk("w0_hi", act(), pv(19'h21, 6'b010111));
    nxt(); mid(); chk("w0_done", 32'(cpu_stall), 32'd0);
    nxt();
    cpu_wr = 1'b0;

    // vreq arrives while the CPU read is in its low cycle.
    cpu_rd = 1'b1;
    nxt();
    vreq = 1'b1; vadr = 18'h20003;
    mid(); chk("cv_clo", act(), pv(19'h20, PRd));
    nxt();
    vreq = 1'b0; vadr = 18'($urandom);
    mid(); chk("cv_chi", act(), pv(19'h21, PRd));
    nxt(); mid();
    chk("cv_done", 32'(cpu_stall), 32'd0);
    chk("cv_rdata", cpu_rdata, ref_word[18'h10]);
    chk("cv_vlo", act(), pv({18'h20003, 1'b0}, PRd));
    nxt();
    cpu_rd = 1'b0;
    mid();
    chk("cv_vhi", act(), pv({18'h20003, 1'b1}, PRd));
    chk("cv_vack_early", 32'(vack), 32'd0);
    nxt(); mid();
    chk("cv_vack", 32'(vack), 32'd1);
    chk("cv_vdata", viddata, ref_word[18'h20003]);
    nxt();

    // CPU read and vreq together in IDLE: video goes first.
    cpu_rd = 1'b1; vreq = 1'b1; vadr = 18'h2000C;
    for (int c = 0; c < 6; c++) begin
      mid();
      if (c < 5) chk("vc_stall", 32'(cpu_stall), 32'd1);
      else begin
        chk("vc_stall_low", 32'(cpu_stall), 32'd0);
        chk("vc_rdata", cpu_rdata, ref_word[18'h10]);
      end
      chk("vc_vack", 32'(vack), 32'(c == 3));
      if (c == 3) chk("vc_vdata", viddata, ref_word[18'h2000C]);
      nxt();
      vreq = 1'b0;
      vadr = 18'($urandom);
    end
    cpu_rd = 1'b0;

    // Back-to-back vreqs during a CPU access collapse into one fetch of the later address.
    nv = 0; cdone = 1'b0; vdat = '0;
    cpu_rd = 1'b1;
    for (int c = 0; c < 12; c++) begin
      vreq = (c == 1 || c == 2);
      vadr = (c == 1) ? 18'h20005 : (c == 2) ? 18'h2000A : 18'($urandom);
      mid();
      if (vack) begin nv++; vdat = viddata; end
      if (cpu_rd && !cpu_stall) cdone = 1'b1;
      nxt();
      if (cdone) cpu_rd = 1'b0;
    end
    chk("dbl_count", 32'(nv), 32'd1);
    chk("dbl_data", vdat, ref_word[18'h2000A]);
    chk("dbl_cpu", 32'(cdone), 32'd1);

    // Randomized mix against a slot schedule: one access per two cycles starting one cycle
    // after the request, video first when both are waiting.
    for (int it = 0; it < 40; it++) begin
      op    = int'($urandom_range(0, 3));
      has_c = (op != 2);
      has_v = (op >= 2);
      is_wr = (op == 0) || (op == 3 && $urandom_range(0, 1) == 1);
      ca    = 18'(18'h00100 + $urandom_range(0, 15));
      va    = 18'(18'h20000 + $urandom_range(0, 15));
      voff  = int'($urandom_range(0, 3));
      t = 1; vs = -1; cs = -1;
      while ((has_v && vs < 0) || (has_c && cs < 0)) begin
        if (has_v && vs < 0 && voff <= t - 1) begin vs = t; t += 2; end
        else if (has_c && cs < 0) begin cs = t; t += 2; end
        else t++;
      end
      cpu_adr = ca; cpu_wdata = $urandom; cpu_ben = 4'($urandom_range(0, 15));
      done_at = -1; vack_at = -1; nv = 0; cdone = 1'b0; rdat = '0; vdat = '0;
      for (int c = 0; c < 12; c++) begin
        cpu_rd = has_c && !cdone && !is_wr;
        cpu_wr = has_c && !cdone && is_wr;
        vreq   = has_v && (c == voff);
        vadr   = vreq ? va : 18'($urandom);
        mid();
        if (vack) begin nv++; vack_at = c; vdat = viddata; end
        if ((cpu_rd || cpu_wr) && !cpu_stall) begin
          cdone = 1'b1; done_at = c; rdat = cpu_rdata;
        end
        nxt();
      end
      cpu_rd = 1'b0; cpu_wr = 1'b0; vreq = 1'b0;
      if (has_c) begin
        chk("rnd_done_cycle", 32'(done_at), 32'(cs + 2));
        if (is_wr) ref_word[ca] = merge(ref_word[ca], cpu_wdata, cpu_ben);
        else chk("rnd_rdata", rdat, ref_word[ca]);
      end
      chk("rnd_vack_count", 32'(nv), 32'(has_v));
      if (has_v) begin
        chk("rnd_vack_cycle", 32'(vack_at), 32'(vs + 2));
        chk("rnd_vdata", vdat, ref_word[va]);
      end
    end

    // Read back every CPU-region word touched by the random writes.
    for (int k = 0; k < 16; k++) begin
      cpu_adr = 18'(18'h00100 + k); cpu_rd = 1'b1;
      repeat (3) nxt();
      mid();
      chk("rb_stall", 32'(cpu_stall), 32'd0);
      chk("rb_data", cpu_rdata, ref_word[cpu_adr]);
      nxt();
      cpu_rd = 1'b0;
      nxt();
    end

    // Reset in VHI aborts the fetch.
    vreq = 1'b1; vadr = 18'h20003;
    nxt();
    vreq = 1'b0;
    nxt();
    #1 rst = 1'b0;
    #1;
    chk("ra_pins", act(), pv(19'h0, PIdle));
    chk("ra_vack", 32'(vack), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ra_viddata", viddata, 32'h0);
    rst = 1'b1;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      nxt();
      mid();
      if (vack) nv++;
    end
    chk("ra_no_vack", 32'(nv), 32'd0);
    chk("ra_viddata_hold", viddata, 32'h0);
    nxt();
    run_vfetch("v048");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
